pp_axi_m_arb: RTL and testbench
===============================

PP_AXI_M_ARB -- requirements
Module: pp_axi_m_arb

Interface
REQ-001 Parameter P_AW, default 32, AXI address width.
REQ-002 Parameter P_DW, default 64, AXI data width.
REQ-003 Parameter P_IDW, default 4, AXI ID width.
REQ-004 clk_core  in  1  core clock; single clock domain.
REQ-005 rst_x  in  1  asynchronous active-low reset.
REQ-006 i_req  in  2  per-requester request; bit0 video fetch, bit1 renderer.
REQ-007 i_wr  in  2  per-requester direction; 1 = write.
REQ-008 i_adrs  in  2*P_AW  per-requester byte address.
REQ-009 i_len  in  2*4  per-requester burst length minus one.
REQ-010 i_wdata  in  2*P_DW  per-requester write data.
REQ-011 i_wstrb  in  2*P_DW/8  per-requester write strobe.
REQ-012 o_ack  out  2  one-cycle pulse: address accepted by AXI.
REQ-013 o_wnext  out  2  one-cycle pulse: write beat consumed; requester advances data.
REQ-014 o_rvalid  out  2  read beat valid for the granted requester.
REQ-015 o_rdata  out  P_DW  read data, shared.
REQ-016 o_rlast  out  1  last read beat.
REQ-017 o_busy  out  1  transaction in flight.
REQ-018 AXI3 master ports o_awid_m..o_rready_m  mixed  per polyphony_axi_def.v widths  single shared master.

Function
REQ-019 FSM states IDLE, RADR, RDAT, WADR, WDAT, WRSP; o_busy = (state != IDLE).
REQ-020 IDLE: any i_req -> latch winner index, address, len, wr; next state RADR (wr=0) or WADR (wr=1).
REQ-021 Requester holds i_req/i_wr/i_adrs/i_len stable until its o_ack; deasserts i_req in the o_ack cycle.
REQ-022 RADR: o_arvalid_m=1, arlen=len, arid=index; on i_arready_m pulse o_ack[idx], go RDAT.
REQ-023 RDAT: o_rready_m=1; o_rvalid[idx]=i_rvalid_m combinationally, o_rdata=i_rdata_m, o_rlast=i_rlast_m; on i_rvalid_m&i_rlast_m go IDLE.
REQ-024 Requesters accept every read beat unconditionally (buffer space checked before request).
REQ-025 WADR: o_awvalid_m=1, awlen=len, awid=index; on i_awready_m pulse o_ack[idx], clear beat counter, go WDAT.
REQ-026 WDAT: o_wvalid_m=1, wdata/wstrb muxed from idx, wid=index, o_wlast_m=(counter==len); on i_wready_m pulse o_wnext[idx], counter+1.
REQ-027 Last write beat accepted -> WRSP; WRSP: o_bready_m=1; on i_bvalid_m go IDLE.
REQ-028 4-bit counter; len 0 = single beat with wlast on first beat; len 15 = 16 beats, no wrap.
REQ-029 Valid held until ready; address/control/data stable while valid; no withdrawal.
REQ-030 Constants: size=log2(P_DW/8), burst=INCR (2'b01), lock/cache/prot/user=0.
REQ-031 Response codes (bresp/rresp) ignored; rid/bid not checked.
REQ-032 Minimum one IDLE cycle between transactions; i_req arriving mid-transaction waits.

Reset
REQ-033 rst_x low asynchronously forces IDLE; all AXI valid/ready, o_ack, o_wnext, o_rvalid, o_busy low; counter, latched fields, last-grant pointer = 0.
REQ-034 Reset mid-transaction abandons it with no o_ack/o_wnext/o_rlast pulse; AXI slave shares the system reset.

Configuration
REQ-035 PP_ARB_RR_EN defined: round-robin; on simultaneous requests, the requester not granted last wins; pointer updates on each grant.
REQ-036 PP_ARB_RR_EN undefined: fixed priority; requester 0 always wins simultaneous requests.

Verification
REQ-037 Req0 read adrs 0x1000 len 3, arready delayed 2 cycles -> arvalid held 3 cycles, arlen 3, arid 0, o_ack[0] one pulse, 4 o_rvalid[0] beats, IDLE after rlast.
REQ-038 Req1 write len 0, wready stalls 1 cycle -> single beat, wlast=1, o_wnext[1] one pulse, bready until bvalid, then IDLE.
REQ-039 Both requesting reads continuously, RR build -> grants alternate 0,1,0,1; fixed build -> all grants to 0.
REQ-040 Write len 15 with random wready -> exactly 16 o_wnext pulses, wlast only on 16th beat, wdata matches requester data in order.
REQ-041 rst_x asserted in RDAT after 2 of 4 beats -> outputs low same cycle, IDLE; a fresh request after release completes normally.

Source files
------------

// File: rtl/pp_axi_m_arb.sv
// Two-requester arbiter onto a single AXI3 master (video fetch = 0, renderer = 1).
// Define PP_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module pp_axi_m_arb #(
    parameter int P_AW  = 32,
    parameter int P_DW  = 64,
    parameter int P_IDW = 4
) (
    input  logic                  clk_core,
    input  logic                  rst_x,
    // requester side
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_wr,
    input  logic [2*P_AW-1:0]     i_adrs,
    input  logic [7:0]            i_len,
    input  logic [2*P_DW-1:0]     i_wdata,
    input  logic [2*P_DW/8-1:0]   i_wstrb,
    output logic [1:0]            o_ack,
    output logic [1:0]            o_wnext,
    output logic [1:0]            o_rvalid,
    output logic [P_DW-1:0]       o_rdata,
    output logic                  o_rlast,
    output logic                  o_busy,
    // AXI3 write address
    output logic [P_IDW-1:0]      o_awid_m,
    output logic [P_AW-1:0]       o_awaddr_m,
    output logic [3:0]            o_awlen_m,
    output logic [2:0]            o_awsize_m,
    output logic [1:0]            o_awburst_m,
    output logic [1:0]            o_awlock_m,
    output logic [3:0]            o_awcache_m,
    output logic [2:0]            o_awprot_m,
    output logic                  o_awuser_m,
    output logic                  o_awvalid_m,
    input  logic                  i_awready_m,
    // AXI3 write data
    output logic [P_IDW-1:0]      o_wid_m,
    output logic [P_DW-1:0]       o_wdata_m,
    output logic [P_DW/8-1:0]     o_wstrb_m,
    output logic                  o_wlast_m,
    output logic                  o_wvalid_m,
    input  logic                  i_wready_m,
    // AXI3 write response
    input  logic [P_IDW-1:0]      i_bid_m,
    input  logic [1:0]            i_bresp_m,
    input  logic                  i_bvalid_m,
    output logic                  o_bready_m,
    // AXI3 read address
    output logic [P_IDW-1:0]      o_arid_m,
    output logic [P_AW-1:0]       o_araddr_m,
    output logic [3:0]            o_arlen_m,
    output logic [2:0]            o_arsize_m,
    output logic [1:0]            o_arburst_m,
    output logic [1:0]            o_arlock_m,
    output logic [3:0]            o_arcache_m,
    output logic [2:0]            o_arprot_m,
    output logic                  o_aruser_m,
    output logic                  o_arvalid_m,
    input  logic                  i_arready_m,
    // AXI3 read data
    input  logic [P_IDW-1:0]      i_rid_m,
    input  logic [P_DW-1:0]       i_rdata_m,
    input  logic [1:0]            i_rresp_m,
    input  logic                  i_rlast_m,
    input  logic                  i_rvalid_m,
    output logic                  o_rready_m
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADR,
        ST_RDAT,
        ST_WADR,
        ST_WDAT,
        ST_WRSP
    } state_t;

    state_t            state, state_nx;
    logic              r_idx;
    logic [P_AW-1:0]   r_adrs;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic              win;
    logic              ack, wnext, rbeat;
    logic              unused_resp;

    // Response codes and IDs are not acted upon.
    assign unused_resp = ^{i_bid_m, i_bresp_m, i_rid_m, i_rresp_m};

`ifdef PP_ARB_RR_EN
    logic r_last;

    always_comb begin
        if (i_req == 2'b11) win = ~r_last;
        else                win = i_req[1];
    end

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x)                          r_last <= 1'b0;
        else if (state == ST_IDLE && |i_req) r_last <= win;
    end
`else
    assign win = ~i_req[0];
`endif

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            state  <= ST_IDLE;
            r_idx  <= 1'b0;
            r_adrs <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && |i_req) begin
                r_idx  <= win;
                r_adrs <= win ? i_adrs[2*P_AW-1:P_AW] : i_adrs[P_AW-1:0];
                r_len  <= win ? i_len[7:4] : i_len[3:0];
            end
            if (state == ST_WADR && i_awready_m) r_cnt <= '0;
            else if (wnext)                      r_cnt <= r_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (|i_req)      state_nx = i_wr[win] ? ST_WADR : ST_RADR;
            ST_RADR: if (i_arready_m) state_nx = ST_RDAT;
            ST_RDAT: if (i_rvalid_m && i_rlast_m) state_nx = ST_IDLE;
            ST_WADR: if (i_awready_m) state_nx = ST_WDAT;
            ST_WDAT: if (i_wready_m && r_cnt == r_len) state_nx = ST_WRSP;
            ST_WRSP: if (i_bvalid_m)  state_nx = ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    assign o_busy      = (state != ST_IDLE);
    assign o_arvalid_m = (state == ST_RADR);
    assign o_rready_m  = (state == ST_RDAT);
    assign o_awvalid_m = (state == ST_WADR);
    assign o_wvalid_m  = (state == ST_WDAT);
    assign o_bready_m  = (state == ST_WRSP);

    assign ack   = (o_arvalid_m && i_arready_m) || (o_awvalid_m && i_awready_m);
    assign wnext = o_wvalid_m && i_wready_m;
    assign rbeat = o_rready_m && i_rvalid_m;

    assign o_ack    = ack   ? (r_idx ? 2'b10 : 2'b01) : 2'b00;
    assign o_wnext  = wnext ? (r_idx ? 2'b10 : 2'b01) : 2'b00;
    assign o_rvalid = rbeat ? (r_idx ? 2'b10 : 2'b01) : 2'b00;
    assign o_rdata  = i_rdata_m;
    assign o_rlast  = rbeat && i_rlast_m;

    assign o_awid_m    = P_IDW'(r_idx);
    assign o_awaddr_m  = r_adrs;
    assign o_awlen_m   = r_len;
    assign o_awsize_m  = 3'($clog2(P_DW/8));
    assign o_awburst_m = 2'b01;
    assign o_awlock_m  = '0;
    assign o_awcache_m = '0;
    assign o_awprot_m  = '0;
    assign o_awuser_m  = 1'b0;

    assign o_wid_m     = P_IDW'(r_idx);
    assign o_wdata_m   = r_idx ? i_wdata[2*P_DW-1:P_DW] : i_wdata[P_DW-1:0];
    assign o_wstrb_m   = r_idx ? i_wstrb[2*P_DW/8-1:P_DW/8] : i_wstrb[P_DW/8-1:0];
    assign o_wlast_m   = o_wvalid_m && (r_cnt == r_len);

    assign o_arid_m    = P_IDW'(r_idx);
    assign o_araddr_m  = r_adrs;
    assign o_arlen_m   = r_len;
    assign o_arsize_m  = 3'($clog2(P_DW/8));
    assign o_arburst_m = 2'b01;
    assign o_arlock_m  = '0;
    assign o_arcache_m = '0;
    assign o_arprot_m  = '0;
    assign o_aruser_m  = 1'b0;

endmodule

// File: tb/tb_pp_axi_m_arb.sv
// Scoreboard bench for pp_axi_m_arb: directed transactions push expected acks/beats,
// a negedge monitor pops and compares whenever the DUT signals ack, wnext or rvalid.
module tb_pp_axi_m_arb;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IDW = 4;

    logic              clk_core = 1'b0;
    logic              rst_x;
    logic [1:0]        i_req, i_wr;
    logic [2*AW-1:0]   i_adrs;
    logic [7:0]        i_len;
    logic [2*DW-1:0]   i_wdata;
    logic [2*DW/8-1:0] i_wstrb;
    logic [1:0]        o_ack, o_wnext, o_rvalid;
    logic [DW-1:0]     o_rdata;
    logic              o_rlast, o_busy;
    logic [IDW-1:0]    o_awid_m, o_wid_m, o_arid_m, i_bid_m, i_rid_m;
    logic [AW-1:0]     o_awaddr_m, o_araddr_m;
    logic [3:0]        o_awlen_m, o_arlen_m, o_awcache_m, o_arcache_m;
    logic [2:0]        o_awsize_m, o_arsize_m, o_awprot_m, o_arprot_m;
    logic [1:0]        o_awburst_m, o_arburst_m, o_awlock_m, o_arlock_m;
    logic              o_awuser_m, o_aruser_m;
    logic              o_awvalid_m, i_awready_m, o_arvalid_m, i_arready_m;
    logic [DW-1:0]     o_wdata_m, i_rdata_m;
    logic [DW/8-1:0]   o_wstrb_m;
    logic              o_wlast_m, o_wvalid_m, i_wready_m;
    logic [1:0]        i_bresp_m, i_rresp_m;
    logic              i_bvalid_m, o_bready_m, i_rlast_m, i_rvalid_m, o_rready_m;

    always #5 clk_core = ~clk_core;

    pp_axi_m_arb #(.P_AW(AW), .P_DW(DW), .P_IDW(IDW)) dut (
        .clk_core(clk_core), .rst_x(rst_x),
        .i_req(i_req), .i_wr(i_wr), .i_adrs(i_adrs), .i_len(i_len),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_ack(o_ack), .o_wnext(o_wnext), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_rlast(o_rlast), .o_busy(o_busy),
        .o_awid_m(o_awid_m), .o_awaddr_m(o_awaddr_m), .o_awlen_m(o_awlen_m),
        .o_awsize_m(o_awsize_m), .o_awburst_m(o_awburst_m), .o_awlock_m(o_awlock_m),
        .o_awcache_m(o_awcache_m), .o_awprot_m(o_awprot_m), .o_awuser_m(o_awuser_m),
        .o_awvalid_m(o_awvalid_m), .i_awready_m(i_awready_m),
        .o_wid_m(o_wid_m), .o_wdata_m(o_wdata_m), .o_wstrb_m(o_wstrb_m),
        .o_wlast_m(o_wlast_m), .o_wvalid_m(o_wvalid_m), .i_wready_m(i_wready_m),
        .i_bid_m(i_bid_m), .i_bresp_m(i_bresp_m), .i_bvalid_m(i_bvalid_m),
        .o_bready_m(o_bready_m),
        .o_arid_m(o_arid_m), .o_araddr_m(o_araddr_m), .o_arlen_m(o_arlen_m),
        .o_arsize_m(o_arsize_m), .o_arburst_m(o_arburst_m), .o_arlock_m(o_arlock_m),
        .o_arcache_m(o_arcache_m), .o_arprot_m(o_arprot_m), .o_aruser_m(o_aruser_m),
        .o_arvalid_m(o_arvalid_m), .i_arready_m(i_arready_m),
        .i_rid_m(i_rid_m), .i_rdata_m(i_rdata_m), .i_rresp_m(i_rresp_m),
        .i_rlast_m(i_rlast_m), .i_rvalid_m(i_rvalid_m), .o_rready_m(o_rready_m)
    );

    typedef struct {
        logic          idx;
        logic          wr;
        logic [AW-1:0] adrs;
        logic [3:0]    len;
    } ack_t;

    typedef struct {
        logic          idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    ack_t  q_ack[$];
    beat_t q_w[$];
    beat_t q_r[$];
    ack_t  m_ack;
    beat_t m_beat;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  last_grant = 1'b0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Expected winner of the arbiter given the current request vector.
    function automatic logic pick(input logic [1:0] req);
`ifdef PP_ARB_RR_EN
        if (req == 2'b11) return ~last_grant;
        return req[1];
`else
        return ~req[0];
`endif
    endfunction

    always @(negedge clk_core) begin
        if (rst_x) begin
            if (o_ack != 2'b00) begin
                if (q_ack.size() == 0) chk("ack_unexpected", {30'b0, o_ack}, 0);
                else begin
                    m_ack = q_ack.pop_front();
                    chk("ack_onehot", {30'b0, o_ack}, m_ack.idx ? 2 : 1);
                    if (m_ack.wr)
                        chk("aw_chan", {o_awvalid_m, o_awaddr_m, o_awlen_m, o_awid_m, o_awsize_m, o_awburst_m},
                            {1'b1, m_ack.adrs, m_ack.len, IDW'(m_ack.idx), 3'd3, 2'b01});
                    else
                        chk("ar_chan", {o_arvalid_m, o_araddr_m, o_arlen_m, o_arid_m, o_arsize_m, o_arburst_m},
                            {1'b1, m_ack.adrs, m_ack.len, IDW'(m_ack.idx), 3'd3, 2'b01});
                end
            end
            if (o_wnext != 2'b00) begin
                if (q_w.size() == 0) chk("wnext_unexpected", {30'b0, o_wnext}, 0);
                else begin
                    m_beat = q_w.pop_front();
                    chk("wnext_onehot", {30'b0, o_wnext}, m_beat.idx ? 2 : 1);
                    chk("w_beat", {o_wdata_m, o_wlast_m, o_wid_m, o_wstrb_m},
                        {m_beat.data, m_beat.last, IDW'(m_beat.idx), 8'hFF});
                end
            end
            if (o_rvalid != 2'b00) begin
                if (q_r.size() == 0) chk("rvalid_unexpected", {30'b0, o_rvalid}, 0);
                else begin
                    m_beat = q_r.pop_front();
                    chk("rvalid_onehot", {30'b0, o_rvalid}, m_beat.idx ? 2 : 1);
                    chk("r_beat", {o_rdata, o_rlast, o_rready_m}, {m_beat.data, m_beat.last, 1'b1});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_core);
        #1;
    endtask

    task automatic wait_addr(input logic wr, output int seen);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr ? o_awvalid_m : o_arvalid_m) begin
                seen = 1;
                return;
            end
            tick;
        end
    endtask

    task automatic set_cmd(input logic idx, input logic wr, input logic [AW-1:0] adrs, input logic [3:0] len);
        ack_t e;
        if (idx) begin i_adrs[2*AW-1:AW] = adrs; i_len[7:4] = len; end
        else     begin i_adrs[AW-1:0]    = adrs; i_len[3:0] = len; end
        i_wr[idx]  = wr;
        i_req[idx] = 1'b1;
        e.idx = idx; e.wr = wr; e.adrs = adrs; e.len = len;
        q_ack.push_back(e);
        last_grant = idx;
    endtask

    // abort_at < len+1 asserts reset while that beat is being presented.
    task automatic do_read(input logic idx, input logic [AW-1:0] adrs, input logic [3:0] len,
                           input int ar_wait, input logic [DW-1:0] base, input int abort_at);
        int    seen, hold;
        beat_t b;
        set_cmd(idx, 1'b0, adrs, len);
        wait_addr(1'b0, seen);
        chk("ar_wait_timeout", seen, 1);
        hold = 1;
        repeat (ar_wait) begin
            tick;
            hold += int'(o_arvalid_m);
        end
        i_arready_m = 1'b1;
        i_req[idx]  = 1'b0;
        tick;
        i_arready_m = 1'b0;
        chk("ar_hold_cycles", hold, ar_wait + 1);
        chk("ar_dropped", o_arvalid_m, 0);
        for (int k = 0; k <= int'(len); k++) begin
            i_rvalid_m = 1'b1;
            i_rdata_m  = base + DW'(k);
            i_rlast_m  = (k == int'(len));
            if (k == abort_at) begin
                #2 rst_x = 1'b0;
                #1;
                chk("rst_outputs_low", {o_busy, o_rvalid, o_rlast, o_rready_m, o_ack, o_wnext,
                                        o_arvalid_m, o_awvalid_m, o_wvalid_m, o_bready_m}, '0);
                last_grant = 1'b0;
                i_rvalid_m = 1'b0;
                i_rlast_m  = 1'b0;
                tick;
                tick;
                rst_x = 1'b1;
                tick;
                chk("rst_idle", o_busy, 0);
                return;
            end
            b.idx = idx; b.data = base + DW'(k); b.last = (k == int'(len));
            q_r.push_back(b);
            tick;
        end
        i_rvalid_m = 1'b0;
        i_rlast_m  = 1'b0;
        chk("rd_idle", o_busy, 0);
    endtask

    // stall_mode: 0 none, 1 one cycle per beat, 2 random 0..2 cycles per beat.
    task automatic do_write(input logic idx, input logic [AW-1:0] adrs, input logic [3:0] len,
                            input int aw_wait, input int stall_mode, input logic [DW-1:0] base);
        int    seen, ns;
        beat_t b;
        set_cmd(idx, 1'b1, adrs, len);
        wait_addr(1'b1, seen);
        chk("aw_wait_timeout", seen, 1);
        repeat (aw_wait) tick;
        i_awready_m = 1'b1;
        i_req[idx]  = 1'b0;
        tick;
        i_awready_m = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (idx) i_wdata[2*DW-1:DW] = base + DW'(k);
            else     i_wdata[DW-1:0]    = base + DW'(k);
            b.idx = idx; b.data = base + DW'(k); b.last = (k == int'(len));
            q_w.push_back(b);
            ns = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (ns) begin
                chk("w_valid_held", o_wvalid_m, 1);
                tick;
            end
            i_wready_m = 1'b1;
            tick;
            i_wready_m = 1'b0;
        end
        chk("bready_up", {o_bready_m, o_wvalid_m}, 2'b10);
        tick;
        chk("bready_held", o_bready_m, 1);
        i_bvalid_m = 1'b1;
        tick;
        i_bvalid_m = 1'b0;
        chk("wr_idle", o_busy, 0);
    endtask

    task automatic arb_test;
        int    seen;
        logic  g;
        ack_t  e;
        beat_t b;
        i_adrs = {32'h0000_3000, 32'h0000_2000};
        i_len  = '0;
        i_wr   = 2'b00;
        i_req  = 2'b11;
        for (int n = 0; n < 4; n++) begin
            g = pick(i_req);
            e.idx = g; e.wr = 1'b0; e.adrs = g ? 32'h3000 : 32'h2000; e.len = 4'd0;
            q_ack.push_back(e);
            last_grant = g;
            wait_addr(1'b0, seen);
            chk("arb_ar_timeout", seen, 1);
            i_arready_m = 1'b1;
            if (n == 3) i_req = 2'b00;
            tick;
            i_arready_m = 1'b0;
            b.idx = g; b.data = 64'hA0 + DW'(n); b.last = 1'b1;
            q_r.push_back(b);
            i_rvalid_m = 1'b1;
            i_rdata_m  = 64'hA0 + DW'(n);
            i_rlast_m  = 1'b1;
            tick;
            i_rvalid_m = 1'b0;
            i_rlast_m  = 1'b0;
        end
        chk("arb_idle", o_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_x = 1'b0;
        i_req = '0; i_wr = '0; i_adrs = '0; i_len = '0; i_wdata = '0; i_wstrb = '1;
        i_awready_m = 1'b0; i_wready_m = 1'b0; i_bvalid_m = 1'b0; i_bid_m = '0; i_bresp_m = '0;
        i_arready_m = 1'b0; i_rvalid_m = 1'b0; i_rlast_m = 1'b0; i_rdata_m = '0;
        i_rid_m = '0; i_rresp_m = '0;
        repeat (3) @(posedge clk_core);
        #1;
        chk("reset_state", {o_busy, o_ack, o_wnext, o_rvalid, o_rlast, o_arvalid_m, o_awvalid_m,
                            o_wvalid_m, o_bready_m, o_rready_m, o_wlast_m}, '0);
        rst_x = 1'b1;
        tick;

        do_read(1'b0, 32'h1000, 4'd3, 2, 64'h1111_0000, 16);
        tick;
        do_write(1'b1, 32'h4000, 4'd0, 1, 1, 64'hBEEF_0001);
        tick;
        arb_test();
        tick;
        do_write(1'b0, 32'h8000, 4'd15, 0, 2, 64'hC0DE_0000);
        tick;
        do_read(1'b0, 32'h5000, 4'd3, 0, 64'h2222_0000, 2);
        do_read(1'b1, 32'h6000, 4'd1, 1, 64'h3333_0000, 16);
        tick;
        chk("queues_drained", q_ack.size() + q_w.size() + q_r.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
